// File: rtl/i2s_tx.sv
// i2s_tx: serializes a mono sample stream to a stereo I2S DAC link (same sample on both slots),
// with a one-entry holding register between the sample strobe and the frame timing.
module i2s_tx #(
    parameter int DATA_WIDTH   = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  vld_i,
    output logic                  sclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  ovf_o,
    output logic                  udf_o
);
    localparam int DW  = $clog2(CLKS_PER_BIT);
    localparam int BW  = $clog2(2 * SLOT_WIDTH);
    localparam int PAD = SLOT_WIDTH - DATA_WIDTH;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLKS_PER_BIT / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_WIDTH - 1);
    localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_WIDTH);

    typedef struct packed {
        logic [DW-1:0]         div;
        logic [BW-1:0]         bits;
        logic                  full;
        logic [DATA_WIDTH-1:0] hold;
        logic [DATA_WIDTH-1:0] frame;
        logic [SLOT_WIDTH-1:0] shift;
        logic                  sclk;
        logic                  lrclk;
        logic                  sdata;
        logic                  ovf;
        logic                  udf;
    } state_t;

    state_t st, nx;
    logic   div_wrap, load, slot_start;

    always_comb begin
        nx         = st;
        div_wrap   = st.div == DIV_LAST;
        load       = div_wrap && st.bits == BIT_LAST;
        nx.div     = div_wrap ? '0 : st.div + 1'b1;
        nx.bits    = load ? '0 : st.bits + BW'(div_wrap);
        nx.ovf     = !load && vld_i && st.full;
        nx.udf     = load && !vld_i && !st.full;
        nx.full    = load ? st.full && vld_i : st.full || vld_i;
        nx.hold    = vld_i && (!load || st.full) ? data_i : st.hold;
        nx.frame   = !load ? st.frame : st.full ? st.hold : vld_i ? data_i : st.frame;
        slot_start = nx.bits == '0 || nx.bits == SLOT_B;
        // each slot opens with the one-bit I2S delay, then the left-justified word shifts out
        if (div_wrap) begin
            nx.shift = slot_start ? {nx.frame, {PAD{1'b0}}} : st.shift << 1;
            nx.sdata = !slot_start && st.shift[SLOT_WIDTH-1];
        end
        nx.sclk  = nx.div >= DIV_HALF;
        nx.lrclk = nx.bits >= SLOT_B;
        if (!en) nx = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= '0;
        else st <= nx;
    end

    assign sclk  = st.sclk;
    assign lrclk = st.lrclk;
    assign sdata = st.sdata;
    assign ovf_o = st.ovf;
    assign udf_o = st.udf;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: decodes the I2S stream back into slot words and checks them against a frame-level model.
module tb_i2s_tx;
    localparam int CPB = 64;
    localparam int SW  = 32;
    localparam int FR  = 2 * SW * CPB;

    logic        clk = 0, rst = 0, en = 0, vld_i = 0;
    logic [23:0] data_i = 0;
    logic        sclk, lrclk, sdata, ovf_o, udf_o;

    i2s_tx dut (
        .clk(clk), .rst(rst), .en(en), .data_i(data_i), .vld_i(vld_i),
        .sclk(sclk), .lrclk(lrclk), .sdata(sdata), .ovf_o(ovf_o), .udf_o(udf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          o1;
        logic [23:0] d1;
        int          o2;
        logic [23:0] d2;
        logic [23:0] exp_w;
    } fvec_t;

    int          o1[8], o2[8];
    logic [23:0] d1[8], d2[8], exp_w[8];
    fvec_t       tab_a[5];
    int          tests = 0, fails = 0;

    int          mon_idx = -1, ovf_cnt = 0, udf_cnt = 0, pad_err = 0;
    logic        mon_lr = 0, sclk_d = 0, lr_d = 0;
    logic [31:0] mon_word = 0;
    logic [31:0] got_w[$];
    logic        got_lr[$];
    longint      last_sr = 0, last_lr = 0, sclk_per = 0, lr_per = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // I2S receiver: bit index restarts whenever lrclk changes, sampled on sclk rise
    always @(negedge clk) begin
        if (ovf_o) ovf_cnt++;
        if (udf_o) udf_cnt++;
        if (sclk && !sclk_d) begin
            if (last_sr != 0) sclk_per = $time - last_sr;
            last_sr = $time;
            mon_idx = (mon_idx >= 0 && lrclk == mon_lr) ? mon_idx + 1 : 0;
            mon_lr = lrclk;
            if (mon_idx == 0) begin
                mon_word = 0;
                if (sdata) pad_err++;
            end else if (mon_idx < SW) mon_word = mon_word | (32'(sdata) << (SW - mon_idx));
            if (mon_idx == SW - 1) begin
                got_w.push_back(mon_word);
                got_lr.push_back(mon_lr);
            end
        end
        if (lrclk && !lr_d) begin
            if (last_lr != 0) lr_per = $time - last_lr;
            last_lr = $time;
        end
        sclk_d = sclk;
        lr_d   = lrclk;
    end

    task automatic clear_plan();
        for (int i = 0; i < 8; i++) begin
            o1[i] = -1; o2[i] = -1; d1[i] = 0; d2[i] = 0; exp_w[i] = 0;
        end
    endtask

    // Frame-level reference: what each frame carries and how many ovf/udf events occur.
    task automatic model(input int nf, output int eo, output int eu);
        logic [23:0] held, sent, sd;
        bit          full, s;
        eo = 0; eu = 0; held = 0; sent = 0; full = 0;
        exp_w[0] = 0;
        for (int k = 0; k < nf; k++) begin
            if (o1[k] >= 0 && o1[k] < FR - 1) begin
                if (full) eo++;
                held = d1[k]; full = 1;
            end
            if (o2[k] >= 0 && o2[k] < FR - 1) begin
                if (full) eo++;
                held = d2[k]; full = 1;
            end
            if (k < nf - 1) begin
                s  = (o1[k] == FR - 1) || (o2[k] == FR - 1);
                sd = (o2[k] == FR - 1) ? d2[k] : d1[k];
                if (full) begin
                    sent = held; full = s; held = sd;
                end else if (s) sent = sd;
                else eu++;
                exp_w[k+1] = sent;
            end
        end
    endtask

    task automatic run_session(input string nm, input int nf, input int e_ovf, input int e_udf);
        got_w.delete(); got_lr.delete();
        mon_idx = -1; ovf_cnt = 0; udf_cnt = 0; pad_err = 0; last_sr = 0; last_lr = 0;
        en = 1;
        for (int c = 0; c < nf * FR - 1; c++) begin
            int k = c / FR;
            int o = c % FR;
            vld_i  = (o == o1[k]) || (o == o2[k]);
            data_i = (o == o2[k]) ? d2[k] : d1[k];
            @(posedge clk); #1;
        end
        vld_i = 0;
        @(negedge clk);
        en = 0;
        @(posedge clk); #1;
        chk({nm, " slot_count"}, got_w.size(), 2 * nf);
        for (int k = 0; k < nf && 2 * k + 1 < got_w.size(); k++)
            for (int s = 0; s < 2; s++) begin
                chk($sformatf("%s f%0d slot%0d word", nm, k, s), got_w[2*k+s], {exp_w[k], 8'h00});
                chk($sformatf("%s f%0d slot%0d lrclk", nm, k, s), got_lr[2*k+s], s);
            end
        chk({nm, " ovf"}, ovf_cnt, e_ovf);
        chk({nm, " udf"}, udf_cnt, e_udf);
        chk({nm, " pad"}, pad_err, 0);
    endtask

    initial begin
        int idle_bad, eo, eu;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {sclk, lrclk, sdata, ovf_o, udf_o}, 0);
        rst = 1;
        idle_bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if ({sclk, lrclk, sdata, ovf_o, udf_o} != 0) idle_bad++;
        end
        chk("idle_outputs", idle_bad, 0);
        @(posedge clk); #1;

        tab_a[0] = '{100, 24'hA5C3F1, -1, 24'h0, 24'h0};
        tab_a[1] = '{-1, 24'h0, -1, 24'h0, 24'hA5C3F1};
        tab_a[2] = '{200, 24'h000001, 210, 24'h7FFFFF, 24'hA5C3F1};
        tab_a[3] = '{-1, 24'h0, FR - 1, 24'h123456, 24'h7FFFFF};
        tab_a[4] = '{-1, 24'h0, -1, 24'h0, 24'h123456};
        clear_plan();
        for (int i = 0; i < 5; i++) begin
            o1[i] = tab_a[i].o1; d1[i] = tab_a[i].d1;
            o2[i] = tab_a[i].o2; d2[i] = tab_a[i].d2; exp_w[i] = tab_a[i].exp_w;
        end
        run_session("table", 5, 1, 1);
        chk("sclk_period", sclk_per, 10 * CPB);
        chk("lrclk_period", lr_per, 10 * FR);

        en = 1;
        for (int c = 0; c < FR + 17 * CPB + 40; c++) begin
            vld_i = (c == 5); data_i = 24'hA5C3F1;
            @(posedge clk); #1;
        end
        vld_i = 0;
        chk("pre_drop sclk/lrclk/sdata", {sclk, lrclk, sdata}, 3'b101);
        en = 0;
        @(posedge clk); #1;
        chk("en_drop outputs", {sclk, lrclk, sdata}, 0);
        repeat (500) @(posedge clk);
        #1;
        clear_plan();
        run_session("restart", 2, 0, 1);

        en = 1;
        for (int c = 0; c < 3000; c++) begin
            vld_i = (c == 5); data_i = 24'h5A5A5A;
            @(posedge clk); #1;
        end
        vld_i = 0;
        chk("pre_reset sclk", sclk, 1);
        #2 rst = 0;
        #1 chk("async_reset outputs", {sclk, lrclk, sdata, ovf_o, udf_o}, 0);
        @(posedge clk); #1;
        rst = 1;
        clear_plan();
        run_session("post_reset", 2, 0, 1);

        clear_plan();
        for (int k = 0; k < 4; k++) begin
            int n  = $urandom_range(0, 2);
            int hi = (k == 3) ? FR - 2 : FR - 1;
            d1[k] = 24'($urandom);
            d2[k] = 24'($urandom);
            if (n == 1) o1[k] = $urandom_range(0, hi);
            if (n == 2) begin
                o1[k] = $urandom_range(0, hi - 1);
                o2[k] = $urandom_range(o1[k] + 1, hi);
            end
        end
        model(4, eo, eu);
        run_session("random", 4, eo, eu);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
